// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer: direction-counter states and
// the per-entry record held in the table.
package branch_target_buffer_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int BTB_ENTRIES_DEFAULT = 16;

    // Widest tag any legal table size can need (the smallest table has 2
    // entries, so 1 index bit). Narrower tags are zero-extended into this
    // field, which keeps the entry layout independent of the table size.
    localparam int TAG_W_MAX = DATA_WIDTH - 3;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_state_e;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W_MAX-1:0]  tag;
        logic [DATA_WIDTH-1:0] target;
        bp_state_e             state;
    } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state function of the 2-bit saturating direction counter.
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  bp_state_e state_i,
    input  logic      taken_i,
    output bp_state_e state_o
);

    // Taken climbs toward ST, not-taken falls toward SNT; both ends saturate.
    always_comb begin
        state_o = state_i;
        unique case (state_i)
            SNT: state_o = taken_i ? WNT : SNT;
            WNT: state_o = taken_i ? WT  : SNT;
            WT:  state_o = taken_i ? ST  : WNT;
            ST:  state_o = taken_i ? ST  : WT;
            default: state_o = state_i;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer. Fetch gets a zero-latency
// prediction for its PC; decode writes resolved outcomes, visible next cycle.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] lookup_pc_i,
    output logic                  hit_o,
    output logic                  predict_taken_o,
    output logic [DATA_WIDTH-1:0] predict_target_o,
    input  logic                  update_en_i,
    input  logic [DATA_WIDTH-1:0] update_pc_i,
    input  logic [DATA_WIDTH-1:0] update_target_i,
    input  logic                  update_taken_i,
    input  logic                  flush_i
);

    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

    typedef logic [IDX_BITS-1:0]  idx_t;
    typedef logic [TAG_W_MAX-1:0] tag_t;

    btb_entry_t entries_q [BTB_ENTRIES];

    // pc[1:0] never selects or tags anything: instructions are word aligned.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

    idx_t lk_idx, up_idx;
    tag_t lk_tag, up_tag;

    assign lk_idx = lookup_pc_i[IDX_BITS+1:2];
    assign up_idx = update_pc_i[IDX_BITS+1:2];

    // Zero-extend the address tags into the fixed-width entry tag field.
    always_comb begin
        lk_tag = '0;
        up_tag = '0;
        lk_tag[TAG_BITS-1:0] = lookup_pc_i[DATA_WIDTH-1:IDX_BITS+2];
        up_tag[TAG_BITS-1:0] = update_pc_i[DATA_WIDTH-1:IDX_BITS+2];
    end

    // ---------------- lookup: straight off the registered table ----------
    btb_entry_t lk_ent;
    assign lk_ent           = entries_q[lk_idx];
    assign hit_o            = lk_ent.valid && (lk_ent.tag == lk_tag);
    assign predict_taken_o  = hit_o & lk_ent.state[1];
    assign predict_target_o = hit_o ? lk_ent.target : '0;

    // ---------------- update path ----------------------------------------
    btb_entry_t up_ent, wr_ent;
    logic       up_hit, wr_en;
    bp_state_e  up_state_nxt;

    assign up_ent = entries_q[up_idx];
    assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

    sat_counter2 u_sat (
        .state_i (up_ent.state),
        .taken_i (update_taken_i),
        .state_o (up_state_nxt)
    );

    // Build the replacement entry: train on a hit, allocate weakly-taken on a
    // taken miss; a not-taken hit keeps the entry valid even at SNT.
    always_comb begin
        wr_en  = 1'b0;
        wr_ent = up_ent;
        if (update_en_i) begin
            if (up_hit) begin
                wr_en        = 1'b1;
                wr_ent.state = up_state_nxt;
                if (update_taken_i) begin
                    wr_ent.target = update_target_i;
                end
            end else if (update_taken_i) begin
                wr_en         = 1'b1;
                wr_ent.valid  = 1'b1;
                wr_ent.tag    = up_tag;
                wr_ent.target = update_target_i;
                wr_ent.state  = WT;
            end
        end
    end

    // Table storage; flush only drops valid bits and overrides any update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            entries_q[up_idx] <= wr_ent;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// array-based model of the table.
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lookup_pc, upd_pc, upd_tgt;
    logic        upd_en, upd_tk, flush;
    logic        hit, ptk;
    logic [31:0] ptgt;

    int n_cmp = 0;
    int n_bad = 0;

    branch_target_buffer #(.BTB_ENTRIES(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_pc_i      (lookup_pc),
        .hit_o            (hit),
        .predict_taken_o  (ptk),
        .predict_target_o (ptgt),
        .update_en_i      (upd_en),
        .update_pc_i      (upd_pc),
        .update_target_i  (upd_tgt),
        .update_taken_i   (upd_tk),
        .flush_i          (flush)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          mv   [N];
    logic [31:0] mtag [N];
    logic [31:0] mtgt [N];
    int          mcnt [N];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> 6;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mv[i] <= 1'b0; mtag[i] <= '0; mtgt[i] <= '0; mcnt[i] <= 0;
            end
        end else if (flush) begin
            for (int i = 0; i < N; i++) mv[i] <= 1'b0;
        end else if (upd_en) begin
            if (mv[idx_of(upd_pc)] && mtag[idx_of(upd_pc)] == tag_of(upd_pc)) begin
                if (upd_tk) begin
                    mcnt[idx_of(upd_pc)] <= (mcnt[idx_of(upd_pc)] == 3) ? 3 : mcnt[idx_of(upd_pc)] + 1;
                    mtgt[idx_of(upd_pc)] <= upd_tgt;
                end else begin
                    mcnt[idx_of(upd_pc)] <= (mcnt[idx_of(upd_pc)] == 0) ? 0 : mcnt[idx_of(upd_pc)] - 1;
                end
            end else if (upd_tk) begin
                mv[idx_of(upd_pc)]   <= 1'b1;
                mtag[idx_of(upd_pc)] <= tag_of(upd_pc);
                mtgt[idx_of(upd_pc)] <= upd_tgt;
                mcnt[idx_of(upd_pc)] <= 2;
            end
        end
    end

    function automatic logic exp_hit(input logic [31:0] pc);
        return mv[idx_of(pc)] && (mtag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s got=%h exp=%h @%0t", nm, fld, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("model", "hit", {31'b0, hit}, {31'b0, exp_hit(lookup_pc)});
        chk("model", "taken", {31'b0, ptk},
            {31'b0, exp_hit(lookup_pc) && (mcnt[idx_of(lookup_pc)] >= 2)});
        chk("model", "target", ptgt, exp_hit(lookup_pc) ? mtgt[idx_of(lookup_pc)] : 32'h0);
    end

    // Directed check with literal expectations; settles 1ns first.
    task automatic chk_out(input string nm, input logic eh, input logic et, input logic [31:0] etg);
        #1;
        chk(nm, "hit", {31'b0, hit}, {31'b0, eh});
        chk(nm, "taken", {31'b0, ptk}, {31'b0, et});
        chk(nm, "target", ptgt, etg);
    endtask

    // Advance to 1ns after the next edge and return inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        upd_en = 1'b0; upd_tk = 1'b0; flush = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        upd_en = 1'b1; upd_pc = pc; upd_tgt = tgt; upd_tk = tk;
        cyc();
    endtask

    logic [31:0] pool [6];

    initial begin
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1040; pool[2] = 32'h0000_3000;
        pool[3] = 32'hFFFF_FFF0; pool[4] = 32'h0000_2004; pool[5] = 32'h0000_8004;

        rst_n = 1'b0; upd_en = 1'b0; upd_tk = 1'b0; flush = 1'b0;
        upd_pc = '0; upd_tgt = '0; lookup_pc = 32'h0000_1000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_out("reset", 1'b0, 1'b0, 32'h0);

        // Allocation; same-cycle lookup sees pre-update contents.
        upd_en = 1'b1; upd_pc = 32'h0000_1000; upd_tgt = 32'h0000_1010; upd_tk = 1'b1;
        chk_out("same_cycle", 1'b0, 1'b0, 32'h0);
        cyc();
        chk_out("alloc", 1'b1, 1'b1, 32'h0000_1010);

        lookup_pc = 32'h0000_1040;
        chk_out("alias_miss", 1'b0, 1'b0, 32'h0);
        upd(32'h0000_1040, 32'h0000_2000, 1'b1);
        lookup_pc = 32'h0000_1000;
        chk_out("evicted", 1'b0, 1'b0, 32'h0);
        lookup_pc = 32'h0000_1040;
        chk_out("alias_hit", 1'b1, 1'b1, 32'h0000_2000);

        // Counter walk on 0x1000 starting from WT.
        lookup_pc = 32'h0000_1000;
        upd(32'h0000_1000, 32'h0000_1010, 1'b1);
        chk_out("realloc_wt", 1'b1, 1'b1, 32'h0000_1010);
        upd(32'h0000_1000, 32'h0000_BEEF, 1'b0);
        chk_out("wnt", 1'b1, 1'b0, 32'h0000_1010);
        upd(32'h0000_1000, 32'h0000_BEEF, 1'b0);
        chk_out("snt", 1'b1, 1'b0, 32'h0000_1010);
        upd(32'h0000_1000, 32'h0000_BEEF, 1'b0);
        chk_out("snt_sat", 1'b1, 1'b0, 32'h0000_1010);
        repeat (4) upd(32'h0000_1000, 32'h0000_1010, 1'b1);
        chk_out("st", 1'b1, 1'b1, 32'h0000_1010);
        upd(32'h0000_1000, 32'h0000_BEEF, 1'b0);
        chk_out("st_to_wt", 1'b1, 1'b1, 32'h0000_1010);
        upd(32'h0000_1000, 32'h0000_BEEF, 1'b0);
        chk_out("wt_to_wnt", 1'b1, 1'b0, 32'h0000_1010);

        // Backward and wrapped targets stored verbatim.
        upd(32'h0000_3000, 32'h0000_2FFC, 1'b1);
        lookup_pc = 32'h0000_3000;
        chk_out("backward", 1'b1, 1'b1, 32'h0000_2FFC);
        upd(32'hFFFF_FFF0, 32'h0000_0010, 1'b1);
        lookup_pc = 32'hFFFF_FFF0;
        chk_out("wrapped", 1'b1, 1'b1, 32'h0000_0010);

        // Flush drops everything; flush beats a simultaneous update.
        flush = 1'b1;
        cyc();
        chk_out("flush_c", 1'b0, 1'b0, 32'h0);
        lookup_pc = 32'h0000_3000;
        chk_out("flush_0", 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        upd(32'h0000_1000, 32'h0000_1010, 1'b1);
        lookup_pc = 32'h0000_1000;
        chk_out("flush_wins", 1'b0, 1'b0, 32'h0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int k = 0; k < 3000; k++) begin
            lookup_pc = ($urandom_range(0, 7) == 0) ? $urandom
                        : (pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)));
            upd_en  = ($urandom_range(0, 1) == 1);
            upd_pc  = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            upd_tgt = $urandom;
            upd_tk  = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            cyc();
        end

        // Asynchronous reset in the middle of a pending update.
        upd(32'h0000_1000, 32'h0000_1234, 1'b1);
        lookup_pc = 32'h0000_1000;
        chk_out("pre_rst", 1'b1, 1'b1, 32'h0000_1234);
        upd_en = 1'b1; upd_pc = 32'h0000_1080; upd_tgt = 32'h0000_5555; upd_tk = 1'b1;
        #1 rst_n = 1'b0;
        chk_out("async_rst", 1'b0, 1'b0, 32'h0);
        cyc();
        rst_n = 1'b1;
        lookup_pc = 32'h0000_1080;
        chk_out("upd_lost", 1'b0, 1'b0, 32'h0);
        cyc();
        chk_out("upd_lost_next", 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
